// File: rtl/mem_loader.sv
// mem_loader: operator-side nibble editor and request/acknowledge writer for the
// operand memory, with hex seven-segment feedback and a lockout while the control unit runs.
module mem_loader #(
    parameter int ADDR_W      = 3,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [2:0]             btn_pulse,
    input  logic                   run_req,
    input  logic                   run_done,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [7:0]             wr_data,
    input  logic                   wr_ack,
    output logic [2**ADDR_W-1:0]   written,
    output logic                   all_loaded,
    output logic                   busy,
    output logic                   err,
    output logic [6:0]             ssegment0,
    output logic [6:0]             ssegment1,
    output logic [6:0]             ssegment2,
    output logic [6:0]             ssegment3
);
    typedef enum logic [1:0] {EDIT, WRITE, LOCK} state_t;
    typedef enum logic [1:0] {F_ADDR, F_HI, F_LO} field_t;

    localparam logic [7:0]        CNT_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [6:0]        G_ZERO   = 7'b1000000;
    localparam logic [6:0]        G_A      = 7'b0001000;
    localparam logic [6:0]        G_H      = 7'b0001001;
    localparam logic [6:0]        G_L      = 7'b1000111;

    state_t                 state_q, state_d;
    field_t                 field_q, field_d;
    logic [ADDR_W-1:0]      addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [7:0]             data_q, data_d, wr_data_q, wr_data_d, cnt_q, cnt_d;
    logic [2**ADDR_W-1:0]   written_q, written_d;
    logic                   all_loaded_q, all_loaded_d, err_q, err_d;
    logic [6:0]             seg0_q, seg0_d, seg1_q, seg1_d, seg2_q, seg2_d, seg3_q, seg3_d;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        field_d      = field_q;
        addr_d       = addr_q;
        data_d       = data_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cnt_d        = cnt_q;
        written_d    = written_q;
        err_d        = err_q;
        case (state_q)
            EDIT: begin
                // run_req outranks every button; commit outranks increment outranks next-field
                if (run_req) begin
                    state_d = LOCK;
                end else if (btn_pulse[2]) begin
                    state_d   = WRITE;
                    wr_addr_d = addr_q;
                    wr_data_d = data_q;
                    cnt_d     = 8'd0;
                end else if (btn_pulse[1]) begin
                    addr_d = field_q == F_ADDR ? addr_q + ADDR_ONE : addr_q;
                    data_d = field_q == F_HI ? {data_q[7:4] + 4'd1, data_q[3:0]} :
                             field_q == F_LO ? {data_q[7:4], data_q[3:0] + 4'd1} : data_q;
                end else if (btn_pulse[0]) begin
                    field_d = field_q == F_ADDR ? F_HI : field_q == F_HI ? F_LO : F_ADDR;
                end
            end
            WRITE: begin
                if (wr_ack) begin
                    state_d           = EDIT;
                    written_d[addr_q] = 1'b1;
                    err_d             = 1'b0;
                    addr_d            = addr_q + ADDR_ONE;
                    field_d           = F_ADDR;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = EDIT;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            LOCK: state_d = (run_done || !run_req) ? EDIT : LOCK;
            default: state_d = EDIT;
        endcase
        all_loaded_d = &written_d;
        seg0_d = hex7(data_q[3:0]);
        seg1_d = hex7(data_q[7:4]);
        seg2_d = hex7(4'(addr_q));
        seg3_d = field_q == F_ADDR ? G_A : field_q == F_HI ? G_H : G_L;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= EDIT;
            field_q      <= F_ADDR;
            addr_q       <= '0;
            data_q       <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            cnt_q        <= '0;
            written_q    <= '0;
            all_loaded_q <= 1'b0;
            err_q        <= 1'b0;
            seg0_q       <= G_ZERO;
            seg1_q       <= G_ZERO;
            seg2_q       <= G_ZERO;
            seg3_q       <= G_A;
        end else begin
            state_q      <= state_d;
            field_q      <= field_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cnt_q        <= cnt_d;
            written_q    <= written_d;
            all_loaded_q <= all_loaded_d;
            err_q        <= err_d;
            seg0_q       <= seg0_d;
            seg1_q       <= seg1_d;
            seg2_q       <= seg2_d;
            seg3_q       <= seg3_d;
        end
    end

    assign wr_en      = state_q == WRITE;
    assign busy       = state_q != EDIT;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign written    = written_q;
    assign all_loaded = all_loaded_q;
    assign err        = err_q;
    assign ssegment0  = seg0_q;
    assign ssegment1  = seg1_q;
    assign ssegment2  = seg2_q;
    assign ssegment3  = seg3_q;
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: randomized scenarios for mem_loader checked against a transaction-level
// model of the operator's address, data byte, edited field, written mask and error flag.
module tb_mem_loader;
    logic clock = 1'b0, reset = 1'b0;
    logic [2:0] btn_pulse = 3'b000;
    logic run_req = 1'b0, run_done = 1'b0, wr_ack = 1'b0;
    logic wr_en, all_loaded, busy, err;
    logic [2:0] wr_addr;
    logic [7:0] wr_data, written;
    logic [6:0] ssegment0, ssegment1, ssegment2, ssegment3;

    int checks = 0, errors = 0;
    int m_addr, m_data, m_field;
    logic [7:0] m_written;
    bit m_err;

    localparam logic [6:0] GA = 7'b0001000, GH = 7'b0001001, GL = 7'b1000111;
    logic [6:0] hexg [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    mem_loader #(.ADDR_W(3), .ACK_TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .btn_pulse(btn_pulse), .run_req(run_req),
        .run_done(run_done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .written(written), .all_loaded(all_loaded), .busy(busy),
        .err(err), .ssegment0(ssegment0), .ssegment1(ssegment1),
        .ssegment2(ssegment2), .ssegment3(ssegment3)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [27:0] disp();
        return {ssegment3, ssegment2, ssegment1, ssegment0};
    endfunction

    function automatic logic [27:0] exp_disp();
        logic [6:0] f;
        f = m_field == 0 ? GA : m_field == 1 ? GH : GL;
        return {f, hexg[m_addr], hexg[m_data / 16], hexg[m_data % 16]};
    endfunction

    task automatic model_reset();
        m_addr = 0; m_data = 0; m_field = 0; m_written = 8'h00; m_err = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        tick();
    endtask

    // one non-commit button pulse in EDIT, mirrored into the model
    task automatic press(input logic [2:0] b);
        btn_pulse = b;
        tick();
        btn_pulse = 3'b000;
        if (b[1]) begin
            if (m_field == 0) m_addr = (m_addr + 1) % 8;
            else if (m_field == 1) m_data = (m_data + 16) % 256;
            else m_data = (m_data / 16) * 16 + (m_data + 1) % 16;
        end else if (b[0]) begin
            m_field = (m_field + 1) % 3;
        end
    endtask

    task automatic set_field(input int f);
        while (m_field != f) press(3'b001);
    endtask

    task automatic set_val(input int a, input int d);
        set_field(0);
        while (m_addr != a) press(3'b010);
        set_field(1);
        while (m_data / 16 != d / 16) press(3'b010);
        set_field(2);
        while (m_data % 16 != d % 16) press(3'b010);
    endtask

    // commit, then ack after d extra cycles (d<0: never); reports how long wr_en stayed high
    task automatic do_write(input logic [2:0] b, input int d, output int hi,
                            output logic [2:0] wa, output logic [7:0] wd, output bit stable);
        btn_pulse = b;
        tick();
        btn_pulse = 3'b000;
        hi = 0; stable = 1; wa = wr_addr; wd = wr_data;
        for (int g = 0; g < 40 && wr_en; g++) begin
            hi++;
            if (wr_addr !== wa || wr_data !== wd) stable = 0;
            wr_ack = (d >= 0 && hi == d + 1);
            tick();
            wr_ack = 1'b0;
        end
        if (d >= 0 && d < 16) begin
            m_written[m_addr] = 1'b1;
            m_err = 0;
            m_addr = (m_addr + 1) % 8;
            m_field = 0;
        end else begin
            m_err = 1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        checks++;
        if ({wr_en, written, all_loaded, busy, err} !== 12'h000) begin
            errors++; $display("FAIL reset_flags: got %h exp 000", {wr_en, written, all_loaded, busy, err});
        end
        checks++;
        if ({wr_addr, wr_data} !== 11'h000) begin
            errors++; $display("FAIL reset_wr: got %h exp 000", {wr_addr, wr_data});
        end
        checks++;
        if (disp() !== {GA, hexg[0], hexg[0], hexg[0]}) begin
            errors++; $display("FAIL reset_disp: got %h exp %h", disp(), {GA, hexg[0], hexg[0], hexg[0]});
        end
        reset = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_edit_sequence();
        do_reset();
        repeat (3) press(3'b010);
        press(3'b001);
        repeat (5) press(3'b010);
        tick();
        checks++;
        if (disp() !== {GH, 7'b0110000, 7'b0010010, 7'b1000000}) begin
            errors++; $display("FAIL edit_seq: got %h exp %h", disp(), {GH, 7'b0110000, 7'b0010010, 7'b1000000});
        end
    endtask

    task automatic test_random_edit();
        logic [2:0] b;
        for (int i = 0; i < 40; i++) begin
            b = 3'($urandom_range(1, 3));
            press(b);
            if ($urandom_range(0, 1) == 1) tick();
            tick();
            checks++;
            if (disp() !== exp_disp()) begin
                errors++; $display("FAIL rand_edit[%0d]: got %h exp %h", i, disp(), exp_disp());
            end
        end
    endtask

    task automatic test_write_ack();
        int hi; logic [2:0] wa; logic [7:0] wd; bit st;
        set_val(7, 8'hA7);
        do_write(3'b100, 2, hi, wa, wd, st);
        checks++;
        if (hi !== 3 || wa !== 3'd7 || wd !== 8'hA7 || !st) begin
            errors++; $display("FAIL write_ack: got hi=%0d a=%0d d=%h st=%0d exp hi=3 a=7 d=a7 st=1", hi, wa, wd, st);
        end
        checks++;
        if (written !== m_written || written[7] !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL write_ack_mask: got %h err=%b exp %h err=0", written, err, m_written);
        end
        tick();
        checks++;
        if (disp() !== exp_disp() || m_addr != 0) begin
            errors++; $display("FAIL write_ack_disp: got %h exp %h", disp(), exp_disp());
        end
    endtask

    task automatic test_timeout();
        int hi; logic [2:0] wa; logic [7:0] wd; bit st;
        set_val(3, $urandom_range(0, 255));
        do_write(3'b100, -1, hi, wa, wd, st);
        checks++;
        if (hi !== 16 || err !== 1'b1 || written !== m_written) begin
            errors++; $display("FAIL timeout: got hi=%0d err=%b w=%h exp hi=16 err=1 w=%h", hi, err, written, m_written);
        end
        tick();
        checks++;
        if (disp() !== exp_disp()) begin
            errors++; $display("FAIL timeout_disp: got %h exp %h", disp(), exp_disp());
        end
        do_write(3'b100, $urandom_range(0, 5), hi, wa, wd, st);
        checks++;
        if (err !== 1'b0 || written !== m_written || wa !== 3'd3) begin
            errors++; $display("FAIL timeout_recover: got err=%b w=%h a=%0d exp err=0 w=%h a=3", err, written, wa, m_written);
        end
    endtask

    task automatic test_all_loaded();
        int hi, d; logic [2:0] wa; logic [7:0] wd; bit st;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            d = $urandom_range(0, 255);
            set_val(m_addr, d);
            do_write(3'b100, $urandom_range(0, 6), hi, wa, wd, st);
            checks++;
            if (wd !== 8'(d) || wa !== 3'(i) || written !== m_written || all_loaded !== (i == 7)) begin
                errors++; $display("FAIL all_loaded[%0d]: got a=%0d d=%h w=%h al=%b exp a=%0d d=%h w=%h al=%b",
                                   i, wa, wd, written, all_loaded, i, d, m_written, i == 7);
            end
        end
        tick();
        checks++;
        if (written !== 8'hFF || disp() !== exp_disp() || m_addr != 0) begin
            errors++; $display("FAIL all_loaded_end: got w=%h disp=%h exp w=ff disp=%h", written, disp(), exp_disp());
        end
    endtask

    task automatic test_priority_lock();
        int hi; logic [2:0] wa; logic [7:0] wd; bit st;
        set_val(5, 8'h3C);
        set_field(1);
        do_write(3'b111, 1, hi, wa, wd, st);
        checks++;
        if (hi !== 2 || wa !== 3'd5 || wd !== 8'h3C) begin
            errors++; $display("FAIL prio_commit: got hi=%0d a=%0d d=%h exp hi=2 a=5 d=3c", hi, wa, wd);
        end
        tick();
        checks++;
        if (disp() !== exp_disp()) begin
            errors++; $display("FAIL prio_disp: got %h exp %h", disp(), exp_disp());
        end
        set_field(2);
        run_req = 1'b1;
        btn_pulse = 3'b111;
        tick();
        btn_pulse = 3'b000;
        checks++;
        if (busy !== 1'b1 || wr_en !== 1'b0) begin
            errors++; $display("FAIL lock_entry: got busy=%b wr_en=%b exp busy=1 wr_en=0", busy, wr_en);
        end
        btn_pulse = 3'b010;
        tick();
        btn_pulse = 3'b100;
        wr_ack = 1'b1;
        tick();
        btn_pulse = 3'b000;
        wr_ack = 1'b0;
        checks++;
        if (busy !== 1'b1 || wr_en !== 1'b0 || written !== m_written) begin
            errors++; $display("FAIL lock_hold: got busy=%b wr_en=%b w=%h exp busy=1 wr_en=0 w=%h", busy, wr_en, written, m_written);
        end
        run_req = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || disp() !== exp_disp()) begin
            errors++; $display("FAIL lock_exit: got busy=%b disp=%h exp busy=0 disp=%h", busy, disp(), exp_disp());
        end
        run_req = 1'b1;
        tick();
        run_done = 1'b1;
        tick();
        run_done = 1'b0;
        run_req = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL lock_done: got busy=%b exp 0", busy);
        end
        wr_ack = 1'b1;
        tick();
        tick();
        wr_ack = 1'b0;
        checks++;
        if (wr_en !== 1'b0 || written !== m_written || err !== m_err) begin
            errors++; $display("FAIL stray_ack: got wr_en=%b w=%h err=%b exp 0 %h %b", wr_en, written, err, m_written, m_err);
        end
    endtask

    task automatic test_run_during_write();
        set_val(2, $urandom_range(0, 255));
        btn_pulse = 3'b100;
        tick();
        btn_pulse = 3'b000;
        run_req = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || wr_en !== 1'b1) begin
            errors++; $display("FAIL run_in_write: got busy=%b wr_en=%b exp 1 1", busy, wr_en);
        end
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        m_written[2] = 1'b1; m_addr = 3; m_field = 0; m_err = 0;
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || written !== m_written) begin
            errors++; $display("FAIL run_after_ack: got wr_en=%b busy=%b w=%h exp 0 0 %h", wr_en, busy, written, m_written);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || wr_en !== 1'b0) begin
            errors++; $display("FAIL run_deferred_lock: got busy=%b wr_en=%b exp 1 0", busy, wr_en);
        end
        run_req = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || disp() !== exp_disp()) begin
            errors++; $display("FAIL run_release: got busy=%b disp=%h exp 0 %h", busy, disp(), exp_disp());
        end
    endtask

    task automatic test_reset_mid_write();
        set_val(6, 8'h5A);
        btn_pulse = 3'b100;
        tick();
        btn_pulse = 3'b000;
        tick();
        checks++;
        if (wr_en !== 1'b1) begin
            errors++; $display("FAIL midreset_pre: got wr_en=%b exp 1", wr_en);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (wr_en !== 1'b0 || written !== 8'h00 || busy !== 1'b0 || all_loaded !== 1'b0) begin
            errors++; $display("FAIL midreset: got wr_en=%b w=%h busy=%b exp 0 00 0", wr_en, written, busy);
        end
        checks++;
        if (disp() !== {GA, hexg[0], hexg[0], hexg[0]}) begin
            errors++; $display("FAIL midreset_disp: got %h exp %h", disp(), {GA, hexg[0], hexg[0], hexg[0]});
        end
        tick();
        reset = 1'b1;
        model_reset();
        tick();
        tick();
        checks++;
        if (wr_en !== 1'b0 || written !== 8'h00 || disp() !== exp_disp()) begin
            errors++; $display("FAIL midreset_after: got wr_en=%b w=%h disp=%h", wr_en, written, disp());
        end
    endtask

    initial begin
        test_reset();
        test_edit_sequence();
        test_random_edit();
        test_write_ack();
        test_timeout();
        test_all_loaded();
        test_priority_lock();
        test_run_during_write();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Operator-side writer for the 8-word x 8-bit data memory that the microprogrammed control unit reads operands from and writes results back to.
- Takes debounced button pulses and lets the operator set an address and a data byte nibble by nibble. It commits each word to memory over a request/acknowledge write port.
- Drives four seven-segment digits showing the current address, the data byte and the field being edited.
- Locks itself out while the control unit is executing.

Parameters:
- ADDR_W, 3: memory address width; memory depth is 2**ADDR_W words.
- ACK_TIMEOUT, 16: cycles to wait for wr_ack before abandoning a write; allowed range 2..255.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn_pulse  in  3  single-cycle debounced pulses. [0] = next field, [1] = increment field, [2] = commit.
- run_req  in  1  control unit is starting or executing; level signal.
- run_done  in  1  single-cycle pulse; control unit has finished.
- wr_en  out  1  write request to memory.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  8  write data.
- wr_ack  in  1  memory has accepted the write; sampled while wr_en=1.
- written  out  2**ADDR_W  bit i set once word i has been written since reset.
- all_loaded  out  1  AND of all bits of written.
- busy  out  1  high in WRITE or LOCK.
- err  out  1  sticky write-timeout flag; cleared by the next successful write.
- ssegment0  out  7  data low nibble, hex.
- ssegment1  out  7  data high nibble, hex.
- ssegment2  out  7  address, hex.
- ssegment3  out  7  field indicator: 'A', 'H' or 'L'.

Behaviour:
- Reset (async, reset=0):
  - State EDIT, field=ADDR, addr=0, data=0.
  - wr_en=0, wr_addr=0, wr_data=0, written=0, all_loaded=0, busy=0, err=0, timeout counter=0.
  - Displays read "0","0","0","A".
  - Reset during WRITE drops wr_en in the same instant; the pending write is abandoned.
- Seven-segment encoding:
  - Active-low, bit order gfedcba, standard hex glyphs; 0 = 1000000, F = 0001110.
  - Field glyphs: 'A' = 0001000, 'H' = 0001001, 'L' = 1000111.
  - Outputs are registered and update one cycle after the value they show changes.
- EDIT state: at most one button action per cycle, priority commit > increment > next field.
  - btn_pulse[0]: field cycles ADDR -> HI -> LO -> ADDR.
  - btn_pulse[1]:
    - ADDR: addr increments modulo 2**ADDR_W (7 wraps to 0).
    - HI: data[7:4] increments modulo 16; data[3:0] is unchanged.
    - LO: data[3:0] increments modulo 16; no carry into HI.
  - btn_pulse[2]: on the next edge, wr_en=1, wr_addr=addr, wr_data=data, state WRITE, timeout counter=0.
  - run_req=1: go to LOCK. run_req takes priority over any button pulse in the same cycle.
- WRITE state:
  - wr_en, wr_addr and wr_data are held stable; all btn_pulse inputs are ignored.
  - wr_ack=1 (earliest in the cycle after wr_en rises): on that edge wr_en=0, written[addr]=1, err=0, addr=addr+1 (wraps), data is kept, field=ADDR, state EDIT.
  - No wr_ack: the counter increments each cycle. When it reaches ACK_TIMEOUT-1 without wr_ack: wr_en=0, err=1, addr unchanged, state EDIT.
  - wr_ack outside WRITE is ignored.
  - run_req asserted during WRITE is deferred: the write completes or times out, then the next cycle enters LOCK.
- LOCK state:
  - busy=1; buttons are ignored and pulses are not queued.
  - Leave to EDIT on run_done=1, or when run_req=0 for one cycle; field, addr and data are retained.
- all_loaded is registered; it rises on the same edge that sets the last written bit.

Test Plan:
- Reset, then three btn_pulse[1] pulses, then btn_pulse[0], then five btn_pulse[1] -> addr=3, data=0x50; ssegment2=0110000 ("3"), ssegment1=0010010 ("5"), ssegment3='H'.
- Set data=0xA7 at addr=7, pulse btn_pulse[2], wr_ack after 2 cycles -> wr_en high for exactly 3 cycles with wr_addr=7, wr_data=0xA7; afterwards written[7]=1, addr=0, field=ADDR.
- Commit with wr_ack never asserted -> wr_en drops after ACK_TIMEOUT=16 cycles, err=1, addr unchanged. A following acknowledged commit -> err=0.
- Commit 8 consecutive words with immediate ack -> written=0xFF and all_loaded=1 on the 8th ack edge; addr wraps to 0.
- btn_pulse=3'b111 in one EDIT cycle -> only the commit occurs; field and data unchanged. The same pulses together with run_req=1 -> LOCK, no write.
- Assert reset low mid-WRITE -> wr_en=0 immediately, written=0, displays "0","0","0","A". run_req during WRITE -> LOCK entered only after the ack.
